npu_mem_responder: RTL and testbench
====================================

# npu_mem_responder

Bus responder for the NPU SoC native memory interface (valid/ready/wstrb/addr/wdata/rdata). It sits on the `top`-level host port and serves three address regions. The first is a 128 KB byte-writable kernel/data SRAM. The second is the accelerator control register. The third is the accelerator status register. It turns host accesses into SRAM reads/writes and into start/stop pulses toward the NPU core.

## Interface
- `MEM_WORDS`, 32768: SRAM depth in 32-bit words (128 KB).
- `WAIT_CYCLES`, 1: extra wait states before `ready`; legal range 1..15.
- `clock`  in  1: sole clock, all state on rising edge.
- `resetn`  in  1: synchronous, active-low reset.
- `valid`  in  1: host request; held until `ready` is seen.
- `ready`  out  1: one-cycle completion strobe.
- `wstrb`  in  4: byte write enables; 0 = read.
- `addr`  in  32: word-aligned byte address; `addr[1:0]` ignored.
- `wdata`  in  32: write data, lane-aligned.
- `rdata`  out  32: read data, valid while `ready`=1.
- `acc_busy`  in  1: NPU core is running.
- `acc_start`  out  1: one-cycle start pulse.
- `acc_start_addr`  out  16: kernel start address, latched with `acc_start`.
- `acc_stop`  out  1: one-cycle stop pulse.

## Operation
- Address decode, using latched `addr` with bits [1:0] forced to 0:
  - SRAM when `addr[31:17]==0` (word index `addr[16:2]`).
  - CTRL when `addr==32'h0002_0000`.
  - STATUS when `addr==32'h0302_0000`.
  - Everything else is UNMAPPED.
- FSM states IDLE, WAIT, RESP, GAP.
  - IDLE: when `valid`=1, latch addr/wstrb/wdata, load wait counter with `WAIT_CYCLES`, go to WAIT.
  - WAIT: decrement the counter. The SRAM read is issued on entry. Go to RESP when the counter reaches 1.
  - RESP: `ready`=1 for exactly one cycle, then go to GAP.
  - GAP: one cycle; `valid` is ignored. Go to IDLE. This prevents a double response if the host drops `valid` late.
- SRAM write: per byte lane where `wstrb[i]`=1, commits in the RESP cycle. Lanes with `wstrb[i]`=0 are untouched.
- SRAM read (`wstrb`=0): the full word is returned on `rdata`. Byte/halfword extraction is the host's job.
- CTRL write, which needs `wstrb[0]`=1 (other lanes ignored):
  - bit1=1: pulse `acc_stop` in the RESP cycle. No start is issued, even if bit0=1.
  - bit0=1 and bit1=0: pulse `acc_start` in the RESP cycle and set `acc_start_addr <= wdata[31:16]` in the same cycle.
  - A CTRL read returns `{acc_start_addr, 16'h0}`.
- STATUS read: `{23'b0, err, 7'b0, busy}`.
  - `busy` = `acc_busy` OR `pending`.
  - `pending` sets with `acc_start` and clears on the first cycle `acc_busy`=1, or on `acc_stop`. This guarantees status never reads idle between start and core pickup.
  - STATUS writes are ignored.
- UNMAPPED: writes are dropped, reads return 32'h0, and the access still completes with normal latency.

## Timing
- `valid` sampled high in IDLE at cycle N → `ready` high at cycle N+1+`WAIT_CYCLES` (N+2 by default), for one cycle only.
- Back-to-back: the next request is accepted no earlier than the cycle after GAP. Minimum period is `WAIT_CYCLES`+3 cycles.
- `rdata` is registered and stable throughout RESP. It holds its last value otherwise. Reset value is 0.
- Reset values: `ready`=0, `rdata`=0, `acc_start`=0, `acc_stop`=0, `acc_start_addr`=0, `pending`=0, `err`=0, FSM=IDLE.
- Reset mid-transaction: the FSM returns to IDLE and the pending write is not committed. SRAM contents are preserved.
- `valid` deasserted during WAIT (protocol violation): the access still completes and `ready` pulses.
- `acc_busy` rising in the same cycle as `acc_stop`: stop wins and `pending` is cleared.

## Configuration
- `NPU_RESP_ERR_EN` defined:
  - Any UNMAPPED access sets sticky `err` (STATUS bit 8).
  - A CTRL write with bit2=1 clears `err`. The clear has priority over a simultaneous set, and bit2 has no other effect.
- `NPU_RESP_ERR_EN` undefined: no `err` register; STATUS bit 8 reads 0 and CTRL bit2 is ignored.

## Test plan
- Word write 32'hA5A5_1234 to 0x00100, read back → `ready` exactly 2 cycles after `valid` (default `WAIT_CYCLES`), `rdata`=32'hA5A5_1234.
- Byte write 8'h7E to 0x00103 (`wstrb`=4'b1000, `wdata`=32'h7E00_0000) over 32'h1111_1111 → readback 32'h7E11_1111; halfword at 0x00102 gives 32'hBEEF_1111 for data 16'hBEEF.
- CTRL write 32'h0040_0001 → one-cycle `acc_start`, `acc_start_addr`=16'h0040. STATUS reads 1 until `acc_busy` falls, then 0. CTRL write 32'h0000_0003 → `acc_stop` pulse only, no `acc_start`.
- Hold `valid` for 3 extra cycles after `ready` → exactly one `ready` pulse and one SRAM write.
- Assert `resetn`=0 during WAIT of a write to 0x00200 (old 32'h0) → no `ready`, and readback after reset = 32'h0.
- With `NPU_RESP_ERR_EN`: read 0x0400_0000 → `rdata`=0 and STATUS=32'h0000_0100. CTRL write 32'h0000_0004 → STATUS=0. Without the macro, STATUS stays 0.

Source files
------------

// File: rtl/npu_mem_responder.sv
// Host-port responder for the NPU SoC: byte-writable SRAM plus accelerator CTRL/STATUS registers.
// Optional build macro NPU_RESP_ERR_EN adds a sticky error flag for unmapped accesses.
module npu_mem_responder #(
  parameter int MEM_WORDS   = 32768,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        valid,
  output logic        ready,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        acc_busy,
  output logic        acc_start,
  output logic [15:0] acc_start_addr,
  output logic        acc_stop
);

  localparam int          IDX_W       = $clog2(MEM_WORDS);
  localparam logic [31:0] CTRL_ADDR   = 32'h0002_0000;
  localparam logic [31:0] STATUS_ADDR = 32'h0302_0000;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [3:0]  wstrb_q;
  logic [31:0] wdata_q;
  logic        pending;
  logic        err_bit;

  logic [31:0] mem [MEM_WORDS];
  logic [31:0] sram_rd;

  logic [31:0]      addr_w;
  logic [IDX_W-1:0] sram_idx;
  logic             is_sram, is_ctrl, is_status, is_unmapped, is_read;
  logic             ctrl_wr, start_req, stop_req, go_resp, mem_we;
  logic [31:0]      rd_word;

  assign addr_w      = addr_q & ~32'h3;
  assign sram_idx    = addr_w[IDX_W+1:2];
  assign is_sram     = (addr_w[31:17] == 15'd0);
  assign is_ctrl     = (addr_w == CTRL_ADDR);
  assign is_status   = (addr_w == STATUS_ADDR);
  assign is_unmapped = !(is_sram || is_ctrl || is_status);
  assign is_read     = (wstrb_q == 4'd0);

  // Stop takes precedence: a CTRL write with bit1 set never starts the core.
  assign ctrl_wr   = is_ctrl && wstrb_q[0];
  assign stop_req  = ctrl_wr && wdata_q[1];
  assign start_req = ctrl_wr && wdata_q[0] && !wdata_q[1];
  assign go_resp   = (state == S_WAIT) && (cnt == 4'd1);

  // Gating with resetn keeps a write from committing if reset lands on the RESP cycle.
  assign mem_we = (state == S_RESP) && is_sram && resetn;

  // NOTE: the SRAM array has no reset; its contents must survive resetn, and a reset
  // branch would also prevent block-RAM inference.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[sram_idx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
    if (state == S_IDLE && valid) sram_rd <= mem[addr[IDX_W+1:2]];
  end

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    rd_word = '0;
    if (is_sram)        rd_word = sram_rd;
    else if (is_ctrl)   rd_word = {acc_start_addr, 16'h0};
    else if (is_status) rd_word = {23'b0, err_bit, 7'b0, acc_busy | pending};
  end

`ifdef NPU_RESP_ERR_EN
  logic err;
  assign err_bit = err;

  // Clear wins over set; the two cannot coincide today but the priority is deliberate.
  always_ff @(posedge clock) begin
    if (!resetn)                           err <= 1'b0;
    else if (go_resp && ctrl_wr && wdata_q[2]) err <= 1'b0;
    else if (go_resp && is_unmapped)       err <= 1'b1;
  end
`else
  assign err_bit = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state          <= S_IDLE;
      cnt            <= '0;
      addr_q         <= '0;
      wstrb_q        <= '0;
      wdata_q        <= '0;
      ready          <= 1'b0;
      rdata          <= '0;
      acc_start      <= 1'b0;
      acc_stop       <= 1'b0;
      acc_start_addr <= '0;
      pending        <= 1'b0;
    end else begin
      ready     <= 1'b0;
      acc_start <= 1'b0;
      acc_stop  <= 1'b0;

      case (state)
        S_IDLE: begin
          if (valid) begin
            addr_q  <= addr;
            wstrb_q <= wstrb;
            wdata_q <= wdata;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (cnt == 4'd1) begin
            state <= S_RESP;
            ready <= 1'b1;
            if (is_read) rdata <= rd_word;
            if (start_req) begin
              acc_start      <= 1'b1;
              acc_start_addr <= wdata_q[31:16];
            end
            if (stop_req) acc_stop <= 1'b1;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESP:  state <= S_GAP;
        default: state <= S_IDLE;
      endcase

      // Pending covers the gap between the start pulse and the core raising acc_busy.
      if (go_resp && stop_req)       pending <= 1'b0;
      else if (go_resp && start_req) pending <= 1'b1;
      else if (acc_busy)             pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_npu_mem_responder.sv
// Directed bench for npu_mem_responder: SRAM lanes, CTRL/STATUS, valid hold, reset abort, error flag.
module tb_npu_mem_responder;

  logic        clock = 1'b0;
  logic        resetn;
  logic        valid;
  logic        ready;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        acc_busy;
  logic        acc_start;
  logic [15:0] acc_start_addr;
  logic        acc_stop;

  int checks = 0;
  int errors = 0;
  int ready_cnt = 0;
  int start_cnt = 0;
  int stop_cnt  = 0;

  localparam logic [31:0] CTRL   = 32'h0002_0000;
  localparam logic [31:0] STATUS = 32'h0302_0000;

  npu_mem_responder dut (
    .clock          (clock),
    .resetn         (resetn),
    .valid          (valid),
    .ready          (ready),
    .wstrb          (wstrb),
    .addr           (addr),
    .wdata          (wdata),
    .rdata          (rdata),
    .acc_busy       (acc_busy),
    .acc_start      (acc_start),
    .acc_start_addr (acc_start_addr),
    .acc_stop       (acc_stop)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle; a pulse of N cycles counts N times.
  always @(negedge clock) begin
    if (ready)     ready_cnt++;
    if (acc_start) start_cnt++;
    if (acc_stop)  stop_cnt++;
  end

  // One host access; lat = cycles from valid asserted to ready seen (0 on timeout).
  task automatic access(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        output logic [31:0] rd, output int lat);
    @(negedge clock);
    valid = 1'b1; addr = a; wstrb = s; wdata = d;
    lat = 0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clock); #1;
      if (ready) begin
        lat = k;
        rd  = rdata;
        break;
      end
    end
    valid = 1'b0; wstrb = '0;
    checks++;
    if (lat == 0) begin
      errors++;
      $display("FAIL access_timeout addr=%h: no ready within 20 cycles", a);
    end
    @(posedge clock); #1;
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_width addr=%h: ready=%b required 0 in GAP", a, ready);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0; valid = 1'b0; wstrb = '0; addr = '0; wdata = '0; acc_busy = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({ready, acc_start, acc_stop, rdata, acc_start_addr} !== 51'd0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b start=%b stop=%b rdata=%h saddr=%h required all 0",
               ready, acc_start, acc_stop, rdata, acc_start_addr);
    end
    @(negedge clock);
    resetn = 1'b1;
  endtask

  task automatic test_word_rw();
    logic [31:0] rd;
    int lat;
    access(32'h0000_0100, 4'hF, 32'hA5A5_1234, rd, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL write_latency: got %0d required 2", lat); end
    access(32'h0000_0100, 4'h0, 32'h0, rd, lat);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL read_latency: got %0d required 2", lat); end
    checks++;
    if (rd !== 32'hA5A5_1234) begin errors++; $display("FAIL word_readback: got %h required a5a51234", rd); end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    int lat;
    access(32'h0000_0100, 4'hF, 32'h1111_1111, rd, lat);
    access(32'h0000_0103, 4'b1000, 32'h7E00_0000, rd, lat);
    access(32'h0000_0100, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h7E11_1111) begin errors++; $display("FAIL byte_lane: got %h required 7e111111", rd); end
    access(32'h0000_0102, 4'b1100, 32'hBEEF_0000, rd, lat);
    access(32'h0000_0100, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hBEEF_1111) begin errors++; $display("FAIL halfword_lane: got %h required beef1111", rd); end
  endtask

  task automatic test_ctrl_status();
    logic [31:0] rd;
    int lat, s0, p0;
    s0 = start_cnt; p0 = stop_cnt;
    access(CTRL, 4'hF, 32'h0040_0001, rd, lat);
    checks++;
    if (start_cnt - s0 !== 1 || stop_cnt - p0 !== 0) begin
      errors++;
      $display("FAIL start_pulse: start=%0d stop=%0d required 1 0", start_cnt - s0, stop_cnt - p0);
    end
    checks++;
    if (acc_start_addr !== 16'h0040) begin errors++; $display("FAIL start_addr: got %h required 0040", acc_start_addr); end
    access(STATUS, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL status_pending: got %h required 00000001", rd); end
    @(negedge clock); acc_busy = 1'b1;
    repeat (2) @(posedge clock);
    access(STATUS, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("FAIL status_busy: got %h required 00000001", rd); end
    @(negedge clock); acc_busy = 1'b0;
    access(STATUS, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL status_idle: got %h required 00000000", rd); end
    access(CTRL, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0040_0000) begin errors++; $display("FAIL ctrl_read: got %h required 00400000", rd); end
    s0 = start_cnt; p0 = stop_cnt;
    access(CTRL, 4'hF, 32'h0000_0003, rd, lat);
    checks++;
    if (start_cnt - s0 !== 0 || stop_cnt - p0 !== 1) begin
      errors++;
      $display("FAIL stop_pulse: start=%0d stop=%0d required 0 1", start_cnt - s0, stop_cnt - p0);
    end
    // Start then stop before the core picks up: pending must be cleared by the stop.
    access(CTRL, 4'hF, 32'h0080_0001, rd, lat);
    access(CTRL, 4'hF, 32'h0000_0002, rd, lat);
    access(STATUS, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL stop_clears_pending: got %h required 00000000", rd); end
    checks++;
    if (acc_start_addr !== 16'h0080) begin errors++; $display("FAIL start_addr2: got %h required 0080", acc_start_addr); end
  endtask

  task automatic test_valid_hold();
    logic [31:0] rd;
    int lat, r0;
    bit seen;
    access(32'h0000_0300, 4'hF, 32'h0000_0000, rd, lat);
    r0 = ready_cnt;
    seen = 1'b0;
    @(negedge clock);
    valid = 1'b1; addr = 32'h0000_0300; wstrb = 4'b0001; wdata = 32'h0000_0001;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(posedge clock); #1;
      seen = ready;
    end
    // Keep valid asserted through RESP and GAP; GAP must not accept it again.
    @(posedge clock); #1;
    valid = 1'b0; wstrb = '0;
    repeat (6) @(posedge clock);
    #1;
    checks++;
    if (ready_cnt - r0 !== 1) begin errors++; $display("FAIL valid_hold_ready: got %0d pulses required 1", ready_cnt - r0); end
    access(32'h0000_0300, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("FAIL valid_hold_data: got %h required 00000001", rd); end
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd;
    int lat, r0;
    access(32'h0000_0200, 4'hF, 32'h0000_0000, rd, lat);
    access(32'h0000_0100, 4'h0, 32'h0, rd, lat);
    r0 = ready_cnt;
    @(negedge clock);
    valid = 1'b1; addr = 32'h0000_0200; wstrb = 4'hF; wdata = 32'hDEAD_BEEF;
    @(posedge clock); #1;
    resetn = 1'b0; valid = 1'b0; wstrb = '0;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if (ready_cnt - r0 !== 0) begin errors++; $display("FAIL reset_abort_ready: got %0d pulses required 0", ready_cnt - r0); end
    checks++;
    if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h required 00000000", rdata); end
    @(negedge clock); resetn = 1'b1;
    access(32'h0000_0200, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL reset_abort_data: got %h required 00000000", rd); end
    access(32'h0000_0100, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'hBEEF_1111) begin errors++; $display("FAIL sram_kept: got %h required beef1111", rd); end
  endtask

  task automatic test_err();
    logic [31:0] rd;
    int lat;
    access(32'h0400_0000, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL unmapped_read: got %h required 00000000", rd); end
    access(STATUS, 4'h0, 32'h0, rd, lat);
`ifdef NPU_RESP_ERR_EN
    checks++;
    if (rd !== 32'h0000_0100) begin errors++; $display("FAIL err_set: got %h required 00000100", rd); end
`else
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL err_absent: got %h required 00000000", rd); end
`endif
    access(CTRL, 4'hF, 32'h0000_0004, rd, lat);
    access(STATUS, 4'h0, 32'h0, rd, lat);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("FAIL err_clear: got %h required 00000000", rd); end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_byte_lanes();
    test_ctrl_status();
    test_valid_hold();
    test_reset_mid_wait();
    test_err();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
